jk_cmd_gen: RTL
===============

Name: jk_cmd_gen

Overview:
- Upstream command stage for the JK state-machine flip-flop.
- Takes three raw, asynchronous, bouncy push-button inputs (set, clear, toggle).
- Synchronizes and debounces each button, then converts each press into single-cycle j/k command pulses.
- Also flags conflicting presses and counts the commands it issues.

Parameters:
- DEBOUNCE_CYCLES, 4: consecutive stable synchronized samples required to accept a level change; legal range ≥2.
- CNT_W, 8: width of the issued-command counter.

Ports:
- clk  input  1  system clock, all logic on rising edge
- reset  input  1  synchronous, active-high reset
- btn_set  input  1  raw set button, asynchronous, may bounce
- btn_clr  input  1  raw clear button, asynchronous, may bounce
- btn_tog  input  1  raw toggle button, asynchronous, may bounce
- j  output  1  registered single-cycle set command to the downstream flip-flop
- k  output  1  registered single-cycle reset command to the downstream flip-flop
- conflict  output  1  registered single-cycle flag: set and clear pressed in the same cycle, no command issued
- cmd_count  output  CNT_W  number of commands issued, wraps modulo 2^CNT_W

Behaviour:
- Reset is synchronous: on a clk edge with reset=1, everything returns to idle.
  - j, k, conflict = 0; cmd_count = 0.
  - All synchronizer flops = 0; all debouncers go to IDLE_LO with counter 0.
- Synchronizer: two-flop chain per button; the debouncer sees only the second-stage output.
- Debouncer per button, 4-state FSM with a counter of width clog2(DEBOUNCE_CYCLES):
  - IDLE_LO: in=1 → WAIT_HI, cnt=0; otherwise stay.
  - WAIT_HI:
    - in=0 → IDLE_LO (glitch rejected, no pulse).
    - in=1 and cnt==DEBOUNCE_CYCLES-1 → IDLE_HI, assert registered rise pulse for one cycle.
    - Otherwise cnt+1.
  - IDLE_HI: in=0 → WAIT_LO, cnt=0; otherwise stay.
  - WAIT_LO:
    - in=1 → IDLE_HI.
    - in=0 and cnt==DEBOUNCE_CYCLES-1 → IDLE_LO; no pulse on release.
    - Otherwise cnt+1.
  - Illegal encoding → IDLE_LO.
- Latency:
  - Raw input first sampled high at edge 1 and held: rise pulse registered at edge DEBOUNCE_CYCLES+3.
  - j/k are registered one edge later, at edge DEBOUNCE_CYCLES+4 (edge 8 for default).
- Encoder, evaluated on the rise pulses of the same cycle:
  - tog rise (any other rises) → j=1, k=1 (toggle command).
  - set rise only → j=1, k=0.
  - clr rise only → j=0, k=1.
  - set and clr rise, no tog → j=0, k=0, conflict=1.
  - No rise → all 0.
- j, k and conflict are each high for exactly one cycle per accepted press, never longer.
- cmd_count increments by 1 on every cycle where j|k is issued; it does not increment on conflict. It wraps from 2^CNT_W-1 to 0.
- Holding a button produces only one command. The next command from that button requires a debounced release (WAIT_LO completes) followed by a new debounced press.
- Reset mid-debounce aborts the press; no pulse is issued.
- A button held through reset release is treated as a fresh press and issues one command after the full latency.

Decomposition:
- Package jk_cmd_pkg:
  - Enum debounce_state_t {IDLE_LO, WAIT_HI, IDLE_HI, WAIT_LO}.
  - Enum jk_cmd_t {CMD_NONE, CMD_SET, CMD_CLR, CMD_TOG}.
  - Default DEBOUNCE_CYCLES constant.
- Sub-module btn_debounce contains the synchronizer, FSM and counter, and outputs a rise pulse; it is instantiated three times.
- The top level holds the encoder, the output registers and cmd_count.

Test Plan:
- Sequences use DEBOUNCE_CYCLES=4 unless noted.
- Reset, then btn_set=1 held 20 cycles → j=1 for exactly one cycle at edge 8 after first sample; k=0, conflict=0, cmd_count=1.
- btn_clr raw pattern 1,1,1,0 then 1 held 12 cycles → the first burst is rejected; exactly one k pulse, 8 edges after the final rise; cmd_count=1.
- btn_set high for 2 cycles, then 0 → no j/k pulse; cmd_count stays 0. Then set held but release bounced (0,1,0 held) → no second command until a fresh debounced press.
- btn_set and btn_clr rise on the same edge and are held → conflict=1 for one cycle, j=k=0, cmd_count unchanged. Repeat with btn_tog also rising on the same edge → j=k=1 for one cycle, conflict=0, cmd_count increments.
- CNT_W=4, 16 separated btn_set presses → cmd_count reads 15 then wraps to 0.
- Assert reset at edge 5 of a held press → no pulse. Keep the button held after reset releases → one j pulse 8 edges after release.

Source files
------------

// File: rtl/jk_cmd_pkg.sv
// Shared types and defaults for the JK command generator.
package jk_cmd_pkg;

  localparam int DEBOUNCE_CYCLES_DEF = 4;

  typedef enum logic [1:0] {
    IDLE_LO = 2'd0,
    WAIT_HI = 2'd1,
    IDLE_HI = 2'd2,
    WAIT_LO = 2'd3
  } debounce_state_t;

  typedef enum logic [1:0] {
    CMD_NONE = 2'd0,
    CMD_SET  = 2'd1,
    CMD_CLR  = 2'd2,
    CMD_TOG  = 2'd3
  } jk_cmd_t;

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchronizer plus debounce FSM; emits a one-cycle pulse on each
// accepted press. Releases are debounced too but produce no pulse.
//
// state   | meaning
// IDLE_LO | button stable released
// WAIT_HI | candidate press, counting stable high samples
// IDLE_HI | button stable pressed
// WAIT_LO | candidate release, counting stable low samples
module btn_debounce
  import jk_cmd_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_i,
  output logic rise_o
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic            sync1_q, sync2_q;
  debounce_state_t state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            rise_q, rise_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      state_q <= IDLE_LO;
      cnt_q   <= '0;
      rise_q  <= 1'b0;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rise_q  <= rise_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rise_d  = 1'b0;
    case (state_q)
      IDLE_LO: begin
        if (sync2_q) begin
          state_d = WAIT_HI;
          cnt_d   = '0;
        end
      end
      WAIT_HI: begin
        if (!sync2_q) begin
          state_d = IDLE_LO;
        end else if (cnt_q == CNT_LAST) begin
          state_d = IDLE_HI;
          rise_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      IDLE_HI: begin
        if (!sync2_q) begin
          state_d = WAIT_LO;
          cnt_d   = '0;
        end
      end
      WAIT_LO: begin
        if (sync2_q) begin
          state_d = IDLE_HI;
        end else if (cnt_q == CNT_LAST) begin
          state_d = IDLE_LO;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE_LO;
        cnt_d   = '0;
      end
    endcase
  end

  assign rise_o = rise_q;

endmodule

// File: rtl/jk_cmd_gen.sv
// Debounces set/clear/toggle buttons and turns each press into registered
// single-cycle j/k commands, with a conflict flag and an issued-command count.
module jk_cmd_gen
  import jk_cmd_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int CNT_W           = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             btn_set,
  input  logic             btn_clr,
  input  logic             btn_tog,
  output logic             j,
  output logic             k,
  output logic             conflict,
  output logic [CNT_W-1:0] cmd_count
);

  logic set_rise, clr_rise, tog_rise;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_set (
    .clk(clk), .reset(reset), .btn_i(btn_set), .rise_o(set_rise)
  );
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_clr (
    .clk(clk), .reset(reset), .btn_i(btn_clr), .rise_o(clr_rise)
  );
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_tog (
    .clk(clk), .reset(reset), .btn_i(btn_tog), .rise_o(tog_rise)
  );

  jk_cmd_t          cmd;
  logic             j_q, j_d;
  logic             k_q, k_d;
  logic             conflict_q, conflict_d;
  logic [CNT_W-1:0] count_q, count_d;

  // Toggle wins over everything; set+clear alone cancel each other out.
  always_comb begin
    cmd        = CMD_NONE;
    conflict_d = 1'b0;
    if (tog_rise) begin
      cmd = CMD_TOG;
    end else if (set_rise && clr_rise) begin
      conflict_d = 1'b1;
    end else if (set_rise) begin
      cmd = CMD_SET;
    end else if (clr_rise) begin
      cmd = CMD_CLR;
    end
    j_d     = (cmd == CMD_SET) || (cmd == CMD_TOG);
    k_d     = (cmd == CMD_CLR) || (cmd == CMD_TOG);
    count_d = count_q;
    if (cmd != CMD_NONE) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      j_q        <= 1'b0;
      k_q        <= 1'b0;
      conflict_q <= 1'b0;
      count_q    <= '0;
    end else begin
      j_q        <= j_d;
      k_q        <= k_d;
      conflict_q <= conflict_d;
      count_q    <= count_d;
    end
  end

  assign j         = j_q;
  assign k         = k_q;
  assign conflict  = conflict_q;
  assign cmd_count = count_q;

endmodule
